// File: rtl/lsu_mem_adapter_pkg.sv
// Shared definitions for the load/store adapter: RV32 load/store funct3
// encodings, adapter FSM states, latency counter width and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the SRAM latency counter; MEM_LAT is limited to 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } lsu_state_e;

    // Only the five load/store widths the core issues are accepted.
    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Halfword on an odd address, or word not on a 4-byte boundary.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

    // Byte lane used by the access: halfwords snap to an even lane and
    // words to lane 0. For aligned accesses this is simply the address offset.
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return {off[1], 1'b0};
            2'b10:   return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_adapter_lane_align.sv
// Byte-lane steering between the core's right-justified data and the
// word-wide SRAM: store byte enables and data shift, load extract and extend.
// Purely combinational.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  web_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] rd_shift;

    assign wdata_o  = wdata_i << {off_i, 3'b000};
    assign rd_shift = rdata_i >> {off_i, 3'b000};

    // Store byte enables from the access size, shifted to the addressed lane.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        web_o = 4'b1111;
        case (funct3_i[1:0])
            2'b00:   web_o = 4'b0001 << off_i;
            2'b01:   web_o = 4'b0011 << off_i;
            default: web_o = 4'b1111;
        endcase
    end

    // Load extraction: pick the low 8/16/32 bits of the shifted word and extend.
    always_comb begin
        rdata_o = rd_shift;
        case (funct3_i)
            F3_B:    rdata_o = {{24{rd_shift[7]}}, rd_shift[7:0]};
            F3_H:    rdata_o = {{16{rd_shift[15]}}, rd_shift[15:0]};
            F3_BU:   rdata_o = {24'h0, rd_shift[7:0]};
            F3_HU:   rdata_o = {16'h0, rd_shift[15:0]};
            default: rdata_o = rd_shift;
        endcase
    end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the core's Memory-Access stage and the
// single-port data SRAM. One access at a time; fixed SRAM read latency MEM_LAT.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// accesses complete with resp_err and never reach the SRAM; otherwise they are
// snapped to the natural lane and proceed normally.
module lsu_mem_adapter
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_web,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      mem_addr_q, mem_wdata_q, resp_rdata_q;
    logic [3:0]       mem_web_q;
    logic             resp_valid_q, resp_err_q;

    logic             accept, req_err;
    logic [2:0]       sel_f3;
    logic [1:0]       sel_off;
    logic [3:0]       lane_web;
    logic [31:0]      lane_wdata, lane_rdata;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err = !f3_legal(req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_err = !f3_legal(req_funct3);
`endif

    // Stores are steered from the live request at acceptance; loads are
    // extracted later from the captured funct3/offset.
    assign sel_f3  = req_ready ? req_funct3 : f3_q;
    assign sel_off = lane_off(sel_f3, req_ready ? req_addr[1:0] : off_q);

    lsu_lane_align u_align (
        .funct3_i (sel_f3),
        .off_i    (sel_off),
        .wdata_i  (req_wdata),
        .rdata_i  (mem_rdata),
        .web_o    (lane_web),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    // Next state and latency count; the counter only advances in WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE:   if (accept) state_d = req_err ? S_DONE : S_ACCESS;
            S_ACCESS: state_d = we_q ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (cnt_q == LAT_LAST) state_d = S_DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture and SRAM drive; write enables live for the ACCESS cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_web_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_web_q <= '0;
            if (accept) begin
                we_q  <= req_we;
                f3_q  <= req_funct3;
                off_q <= req_addr[1:0];
                if (!req_err) begin
                    mem_addr_q <= {req_addr[31:2], 2'b00};
                    if (req_we) begin
                        mem_web_q   <= lane_web;
                        mem_wdata_q <= lane_wdata;
                    end
                end
            end
        end
    end

    // Response: one-cycle valid pulse on entry to DONE; data and error hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept && req_err) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= '0;
                end
                S_ACCESS: if (we_q) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                S_WAIT: if (cnt_q == LAT_LAST) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= lane_rdata;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_web    = mem_web_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter (MEM_LAT = 3). Expected behaviour
// comes from a byte-size/offset reference model; mem_rdata carries the real
// word only in the cycle the adapter must sample it and noise otherwise.
module tb_lsu_mem_adapter;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_web;

    int          n_cmp = 0;
    int          n_bad = 0;
    string       cur_txn = "init";
    logic [31:0] last_maddr = '0;

    lsu_mem_adapter #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_web    (mem_web),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL [%s] %s: got 0x%08h, expected 0x%08h", cur_txn, tag, got, exp);
        end
    endtask

    typedef struct {
        bit          err;
        logic [3:0]  web;
        logic [31:0] mwdata;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    // Reference: access size and byte offset, then plain shifts and arithmetic.
    function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rw);
        exp_t        e;
        int          size;
        int          off;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off  = int'(addr % 4);
        e.err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % size != 0) e.err = 1'b1;
`else
        off = off - (off % size);
`endif
        e.web = '0; e.mwdata = '0; e.rdata = '0;
        if (e.err) begin
            e.lat = 1;
        end else if (we) begin
            e.lat = 2;
            for (int b = 0; b < size; b++) e.web[off + b] = 1'b1;
            e.mwdata = wd << (8 * off);
        end else begin
            e.lat = 2 + LAT;
            v = rw >> (8 * off);
            if (size < 4) begin
                v = v % (32'd1 << (8 * size));
                if (!f3[2] && v[8 * size - 1]) v = v - (32'd1 << (8 * size));
            end
            e.rdata = v;
        end
        return e;
    endfunction

    // One complete transaction, entered and left #1 after a rising edge.
    task automatic run_req(input string nm, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rw);
        exp_t e;
        e = model(we, f3, addr, wd, rw);
        cur_txn = nm;
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        mem_rdata = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (!e.err) last_maddr = {addr[31:2], 2'b00};
        for (int k = 1; k <= e.lat + 1; k++) begin
            mem_rdata = (!we && !e.err && k == 1 + LAT) ? rw : $urandom;
            check($sformatf("resp_valid@%0d", k), resp_valid, (k == e.lat));
            check($sformatf("req_ready@%0d", k), req_ready, (k > e.lat));
            check($sformatf("mem_web@%0d", k), mem_web, (k == 1 && we && !e.err) ? e.web : 4'h0);
            check($sformatf("mem_addr@%0d", k), mem_addr, last_maddr);
            if (k == 1 && we && !e.err) check("mem_wdata", mem_wdata, e.mwdata);
            if (k >= e.lat) begin
                check($sformatf("resp_err@%0d", k), resp_err, e.err);
                check($sformatf("resp_rdata@%0d", k), resp_rdata, e.rdata);
            end
            if (k <= e.lat) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        logic [2:0] f3;
        bit         we;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        cur_txn = "reset";
        check("req_ready", req_ready, 1);
        check("resp_valid", resp_valid, 0);
        check("resp_rdata", resp_rdata, 0);
        check("resp_err", resp_err, 0);
        check("mem_addr", mem_addr, 0);
        check("mem_web", mem_web, 0);
        check("mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases.
        run_req("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0);
        run_req("sb_103", 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0);
        run_req("sh_102", 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0);
        run_req("lb_102", 1'b0, 3'b000, 32'h102, 32'h0, 32'h12F45678);
        run_req("lbu_102", 1'b0, 3'b100, 32'h102, 32'h0, 32'h12F45678);
        run_req("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000);
        run_req("lhu_102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_0000);
        run_req("lw_200", 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D);
        run_req("lh_101", 1'b0, 3'b001, 32'h101, 32'h0, 32'h12F45678);
        run_req("sw_103", 1'b1, 3'b010, 32'h103, 32'h55AA_33CC, 32'h0);
        run_req("ld_f3_011", 1'b0, 3'b011, 32'h104, 32'h0, 32'h1111_2222);
        run_req("st_f3_111", 1'b1, 3'b111, 32'h108, 32'h9999_9999, 32'h0);

        // Reset during the ACCESS cycle of a store.
        cur_txn = "rst_mid";
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h300; req_wdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("web_in_access", mem_web, 4'hF);
        rst = 1'b1;
        #1;
        check("web_after_rst", mem_web, 0);
        check("resp_valid_rst", resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_maddr = '0;
        for (int k = 0; k < LAT + 3; k++) begin
            check("no_resp", resp_valid, 0);
            check("ready_idle", req_ready, 1);
            @(posedge clk); #1;
        end

        // Randomised traffic; stores use only the S* encodings or illegal ones.
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            if (we && (f3 == 3'd4 || f3 == 3'd5)) f3 = 3'd3;
            run_req($sformatf("rand%0d", i), we, f3, $urandom, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
